// File: rtl/systolic_pkg.sv
// Shared types and constants for the activation feed path.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feed_state_t;

    localparam int DIM_DEF       = 32;
    localparam int UB_RD_LAT_DEF = 1;

    // Cycles spent after the last read issue before completion: buffer latency,
    // one cycle of staging register, then the full diagonal skew across DIM lanes.
    function automatic int drain_len(input int rd_lat, input int dim);
        return rd_lat + dim + 1;
    endfunction

    localparam int DRAIN_LEN_DEF = drain_len(UB_RD_LAT_DEF, DIM_DEF);

endpackage

// File: rtl/feed_delay_line.sv
// 1-bit shift register used to align strobes with buffer and staging latency.
// Latency: DEPTH cycles from d_i to q_o.
// Backpressure: none; clr_i empties the line (including the bit presented that cycle).
module feed_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    // Next value of the line: new bit enters at stage 0, everything moves up one.
    always_comb begin
        shift_d    = '0;
        shift_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    // Line storage; a synchronous clear wipes all in-flight strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequences one unified-buffer read per row into the systolic staging block, then waits out the skew.
// Latency: first read 1 cycle after accept; done_o UB_RD_LAT+DIM+2 cycles after the last read.
// Backpressure: cmd_ready_o only in IDLE; pause_i stalls read issue 1:1; weights_rdy_i gates feed start.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int DIM       = DIM_DEF,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 16,
    parameter int UB_RD_LAT = UB_RD_LAT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_base_i,
    input  logic [LEN_W-1:0]  cmd_rows_i,
    input  logic              weights_rdy_i,
    input  logic              pause_i,
    input  logic              abort_i,
    output logic              ub_rd_en_o,
    output logic [ADDR_W-1:0] ub_addr_o,
    output logic              stage_read_o,
    output logic              first_out_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int                DRAIN_LEN  = drain_len(UB_RD_LAT, DIM);
    localparam int                DCNT_W     = $clog2(DRAIN_LEN);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_LEN - 1);

    feed_state_t       state_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  rows_q;
    logic [LEN_W-1:0]  issued_q;
    logic [DCNT_W-1:0] drain_q;

    logic rd_en;
    logic last_issue;
    logic first_issue;

    // Reads go out every FEED cycle that is not paused; the count tops out at
    // rows, so even the all-ones row count never wraps issued_q.
    assign rd_en       = (state_q == FEED) && !pause_i;
    assign last_issue  = rd_en && (issued_q == rows_q - LEN_W'(1));
    assign first_issue = rd_en && (issued_q == '0);

    // Command sequencer: accept, wait for weights, issue reads, drain skew, signal done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            base_q   <= '0;
            rows_q   <= '0;
            issued_q <= '0;
            drain_q  <= '0;
        end else if (abort_i) begin
            state_q  <= IDLE;
            issued_q <= '0;
            drain_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        base_q   <= cmd_base_i;
                        rows_q   <= cmd_rows_i;
                        issued_q <= '0;
                        drain_q  <= '0;
                        if (cmd_rows_i == '0) begin
                            state_q <= DONE;
                        end else if (!weights_rdy_i) begin
                            state_q <= WAIT_W;
                        end else begin
                            state_q <= FEED;
                        end
                    end
                end
                WAIT_W: begin
                    if (weights_rdy_i) begin
                        state_q <= FEED;
                    end
                end
                FEED: begin
                    if (rd_en) begin
                        issued_q <= issued_q + LEN_W'(1);
                        if (last_issue) begin
                            state_q <= DRAIN;
                            drain_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q + DCNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign ub_rd_en_o  = rd_en;
    assign ub_addr_o   = base_q + ADDR_W'(issued_q);

    // Buffer data arrives UB_RD_LAT cycles after the read strobe.
    feed_delay_line #(
        .DEPTH (UB_RD_LAT)
    ) u_stage_dly (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (abort_i),
        .d_i    (rd_en),
        .q_o    (stage_read_o)
    );

    // Lane 0 shows row 0 two cycles after the staging block captures it.
    feed_delay_line #(
        .DEPTH (UB_RD_LAT + 2)
    ) u_first_dly (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (abort_i),
        .d_i    (first_issue),
        .q_o    (first_out_o)
    );

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with DIM=32, UB_RD_LAT=1.
// Cycle 0 is the cycle a command is presented; outputs are sampled on the falling edge.
// Flag vectors are {ub_rd_en, stage_read, first_out, done, busy, cmd_ready}.
module tb_systolic_feed_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [15:0] cmd_base_i = '0;
    logic [15:0] cmd_rows_i = '0;
    logic        weights_rdy_i = 1'b0;
    logic        pause_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        ub_rd_en_o;
    logic [15:0] ub_addr_o;
    logic        stage_read_o;
    logic        first_out_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    logic [5:0]  flags_a [0:63];
    logic [15:0] addr_a  [0:63];

    systolic_feed_ctrl #(
        .DIM       (32),
        .ADDR_W    (16),
        .LEN_W     (16),
        .UB_RD_LAT (1)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_base_i    (cmd_base_i),
        .cmd_rows_i    (cmd_rows_i),
        .weights_rdy_i (weights_rdy_i),
        .pause_i       (pause_i),
        .abort_i       (abort_i),
        .ub_rd_en_o    (ub_rd_en_o),
        .ub_addr_o     (ub_addr_o),
        .stage_read_o  (stage_read_o),
        .first_out_o   (first_out_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus driver: entered and left just after a rising edge. Records ncyc cycles.
    task automatic run_cmd(input logic [15:0] base, input logic [15:0] rows,
                           input int v_last, input int w_lo, input int w_hi,
                           input int p_lo, input int p_hi, input int ab_cyc,
                           input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            cmd_valid_i   = (c <= v_last);
            cmd_base_i    = base;
            cmd_rows_i    = rows;
            weights_rdy_i = (c >= w_lo) && (c <= w_hi);
            pause_i       = (c >= p_lo) && (c <= p_hi);
            abort_i       = (c == ab_cyc);
            @(negedge clk_i);
            flags_a[c] = {ub_rd_en_o, stage_read_o, first_out_o, done_o, busy_o, cmd_ready_o};
            addr_a[c]  = ub_addr_o;
            @(posedge clk_i);
            #1;
        end
        cmd_valid_i   = 1'b0;
        weights_rdy_i = 1'b0;
        pause_i       = 1'b0;
        abort_i       = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({ub_rd_en_o, stage_read_o, first_out_o, done_o, busy_o, cmd_ready_o} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags got %b want 000001",
                     {ub_rd_en_o, stage_read_o, first_out_o, done_o, busy_o, cmd_ready_o});
        end
        checks++;
        if (ub_addr_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_addr got %h want 0000", ub_addr_o);
        end
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_basic();
        logic [5:0] exp;
        run_cmd(16'h0010, 16'd4, 0, 0, 1000, -1, -1, -1, 42);
        for (int c = 0; c < 42; c++) begin
            exp = {c >= 1 && c <= 4, c >= 2 && c <= 5, c == 4, c == 39, c >= 1 && c <= 39, c == 0 || c >= 40};
            checks++;
            if (flags_a[c] !== exp) begin
                errors++;
                $display("FAIL basic_flags cyc %0d got %b want %b", c, flags_a[c], exp);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (addr_a[c] !== 16'(16'h0010 + c - 1)) begin
                    errors++;
                    $display("FAIL basic_addr cyc %0d got %h want %h", c, addr_a[c], 16'(16'h0010 + c - 1));
                end
            end
        end
    endtask

    // Weights arrive at cycle 10 and drop again during FEED, which must not matter.
    task automatic test_wait_weights();
        logic [5:0] exp;
        run_cmd(16'h0010, 16'd4, 0, 10, 11, -1, -1, -1, 52);
        for (int c = 0; c < 52; c++) begin
            exp = {c >= 11 && c <= 14, c >= 12 && c <= 15, c == 14, c == 49, c >= 1 && c <= 49, c == 0 || c >= 50};
            checks++;
            if (flags_a[c] !== exp) begin
                errors++;
                $display("FAIL wait_flags cyc %0d got %b want %b", c, flags_a[c], exp);
            end
            if (c >= 11 && c <= 14) begin
                checks++;
                if (addr_a[c] !== 16'(16'h0010 + c - 11)) begin
                    errors++;
                    $display("FAIL wait_addr cyc %0d got %h want %h", c, addr_a[c], 16'(16'h0010 + c - 11));
                end
            end
        end
    endtask

    task automatic test_pause();
        logic [5:0]  exp;
        logic [15:0] exp_addr;
        run_cmd(16'h0100, 16'd3, 0, 0, 1000, 2, 3, -1, 43);
        for (int c = 0; c < 43; c++) begin
            exp = {c == 1 || c == 4 || c == 5, c == 2 || c == 5 || c == 6, c == 4, c == 40,
                   c >= 1 && c <= 40, c == 0 || c >= 41};
            checks++;
            if (flags_a[c] !== exp) begin
                errors++;
                $display("FAIL pause_flags cyc %0d got %b want %b", c, flags_a[c], exp);
            end
        end
        for (int k = 0; k < 3; k++) begin
            exp_addr = 16'h0100 + 16'(k);
            checks++;
            if (addr_a[k == 0 ? 1 : k + 3] !== exp_addr) begin
                errors++;
                $display("FAIL pause_addr read %0d got %h want %h", k, addr_a[k == 0 ? 1 : k + 3], exp_addr);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] exp_addr [0:2];
        exp_addr[0] = 16'hFFFE;
        exp_addr[1] = 16'hFFFF;
        exp_addr[2] = 16'h0000;
        run_cmd(16'hFFFE, 16'd3, 0, 0, 1000, -1, -1, -1, 40);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (flags_a[k+1][5] !== 1'b1 || addr_a[k+1] !== exp_addr[k]) begin
                errors++;
                $display("FAIL wrap_addr cyc %0d got en=%b addr=%h want en=1 addr=%h",
                         k + 1, flags_a[k+1][5], addr_a[k+1], exp_addr[k]);
            end
        end
        checks++;
        if (flags_a[38][2] !== 1'b1 || flags_a[39][0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done got done38=%b ready39=%b want 1 1", flags_a[38][2], flags_a[39][0]);
        end
    endtask

    task automatic test_zero_rows();
        logic [5:0] exp;
        run_cmd(16'h0555, 16'd0, 0, 0, 1000, -1, -1, -1, 5);
        for (int c = 0; c < 5; c++) begin
            exp = {1'b0, 1'b0, 1'b0, c == 1, c == 1, c != 1};
            checks++;
            if (flags_a[c] !== exp) begin
                errors++;
                $display("FAIL zero_flags cyc %0d got %b want %b", c, flags_a[c], exp);
            end
        end
    endtask

    // cmd_valid held high: a new command is taken only once back in IDLE.
    task automatic test_back_to_back();
        logic [5:0] exp;
        run_cmd(16'h0000, 16'd0, 3, 0, 1000, -1, -1, -1, 6);
        for (int c = 0; c < 6; c++) begin
            exp = {1'b0, 1'b0, 1'b0, c == 1 || c == 3, c == 1 || c == 3, !(c == 1 || c == 3)};
            checks++;
            if (flags_a[c] !== exp) begin
                errors++;
                $display("FAIL b2b_flags cyc %0d got %b want %b", c, flags_a[c], exp);
            end
        end
    endtask

    task automatic test_abort();
        run_cmd(16'h0020, 16'd8, 0, 0, 1000, -1, -1, 3, 46);
        checks++;
        if (flags_a[3][1] !== 1'b1 || flags_a[3][0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre got busy=%b ready=%b want 1 0", flags_a[3][1], flags_a[3][0]);
        end
        for (int c = 4; c < 46; c++) begin
            checks++;
            if (flags_a[c] !== 6'b000001) begin
                errors++;
                $display("FAIL abort_idle cyc %0d got %b want 000001", c, flags_a[c]);
            end
        end
        // A fresh command after the abort runs normally.
        run_cmd(16'h0040, 16'd2, 0, 0, 1000, -1, -1, -1, 39);
        for (int c = 0; c < 39; c++) begin
            checks++;
            if (flags_a[c] !== {c >= 1 && c <= 2, c >= 2 && c <= 3, c == 4, c == 37, c >= 1 && c <= 37, c == 0 || c >= 38}) begin
                errors++;
                $display("FAIL post_abort_flags cyc %0d got %b", c, flags_a[c]);
            end
        end
        checks++;
        if (addr_a[2] !== 16'h0041) begin
            errors++;
            $display("FAIL post_abort_addr got %h want 0041", addr_a[2]);
        end
    endtask

    // Reset dropped while in DRAIN (rows=1: read cycle 1, DRAIN from cycle 2).
    task automatic test_reset_in_drain();
        cmd_valid_i   = 1'b1;
        cmd_base_i    = 16'h0300;
        cmd_rows_i    = 16'd1;
        weights_rdy_i = 1'b1;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        @(posedge clk_i);
        #2;
        checks++;
        if ({stage_read_o, busy_o, cmd_ready_o} !== 3'b110) begin
            errors++;
            $display("FAIL drain_pre got %b want 110", {stage_read_o, busy_o, cmd_ready_o});
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({ub_rd_en_o, stage_read_o, first_out_o, done_o, busy_o, cmd_ready_o} !== 6'b000001) begin
            errors++;
            $display("FAIL drain_reset_flags got %b want 000001",
                     {ub_rd_en_o, stage_read_o, first_out_o, done_o, busy_o, cmd_ready_o});
        end
        checks++;
        if (ub_addr_o !== 16'h0000) begin
            errors++;
            $display("FAIL drain_reset_addr got %h want 0000", ub_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk_i);
            checks++;
            if ({first_out_o, done_o, busy_o} !== 3'b000) begin
                errors++;
                $display("FAIL drain_after_reset cyc %0d got first/done/busy %b want 000", c,
                         {first_out_o, done_o, busy_o});
            end
        end
        weights_rdy_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_wait_weights();
        test_pause();
        test_addr_wrap();
        test_zero_rows();
        test_back_to_back();
        test_abort();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for the activation path into the systolic array. It accepts a feed command (unified-buffer base address, row count) and issues one unified-buffer read per row. It drives the staging block's read strobe aligned with buffer read latency, then waits out the diagonal skew. When the last lane has emitted its final row it pulses done. It sits between the top-level command decoder and the unified buffer / systolic data staging pair.

## Interface
- DIM, 32, array width; staging lanes
- ADDR_W, 16, unified-buffer address width
- LEN_W, 16, row-count width
- UB_RD_LAT, 1, unified-buffer read latency in cycles (≥1)
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  high only in IDLE
- cmd_base_i  in  ADDR_W  first row address
- cmd_rows_i  in  LEN_W  number of rows (0 legal)
- weights_rdy_i  in  1  weight tiles loaded in array; feeding may start
- pause_i  in  1  suppresses read issue this cycle (FEED only)
- abort_i  in  1  synchronous abort
- ub_rd_en_o  out  1  unified-buffer read enable
- ub_addr_o  out  ADDR_W  unified-buffer read address
- stage_read_o  out  1  to staging read strobe; high in cycles carrying valid buffer data
- first_out_o  out  1  pulse: lane 0 presents row 0
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, WAIT_W, FEED, DRAIN, DONE.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch base/rows. If rows==0, go to DONE. Otherwise go to WAIT_W if !weights_rdy_i, else FEED.
- WAIT_W → FEED when weights_rdy_i=1.
- FEED: ub_rd_en_o = !pause_i (combinational from state and pause_i). ub_addr_o = base + issued count, modulo 2^ADDR_W (wraps silently). Issued count increments on each enable. After the rows-th issue, go to DRAIN.
- DRAIN: counter runs UB_RD_LAT+DIM+1 cycles after the last issue cycle, then DONE.
- DONE: done_o=1 for one cycle, then IDLE. A command is not accepted in DONE.
- stage_read_o = ub_rd_en_o delayed UB_RD_LAT cycles (shift register).
- first_out_o = the first ub_rd_en_o of a command, delayed UB_RD_LAT+2.
- abort_i, in any state: go to IDLE next cycle. Clear the delay shift registers and counters. No done_o. abort_i takes priority over cmd_valid_i in the same cycle.
- weights_rdy_i deasserting during FEED/DRAIN is ignored.
- Issued count is LEN_W wide; rows = 2^LEN_W−1 must complete without overflow.

## Timing
- Reset values: state IDLE; cmd_ready_o=1; all other outputs 0; ub_addr_o=0; shift registers cleared.
- Reset asserted mid-command returns to IDLE immediately (asynchronous). No done_o is generated for that command.
- Command accepted at cycle 0 with weights ready: first ub_rd_en_o in cycle 1.
- Read issued at cycle r: stage_read_o high at r+UB_RD_LAT. The staging block presents lane i's data at r+UB_RD_LAT+2+i.
- Last issue at cycle L: done_o in cycle L+UB_RD_LAT+DIM+2, which is the cycle after lane DIM−1 shows the last row.
- rows==0: done_o in cycle 1; no reads.
- Pause cycles add a 1:1 delay; each appears as a zero bubble at the staging input.
- Back-to-back: the next command is accepted no earlier than the cycle after done_o.

## Structure
- Package systolic_pkg: state enum feed_state_t, DIM, UB_RD_LAT defaults, drain-length constant (UB_RD_LAT+DIM+1).
- One sub-module: feed_delay_line (parameterised 1-bit shift register with synchronous clear). Instantiated for stage_read_o and first_out_o.

## Test plan
- base=0x0010, rows=4, weights ready, DIM=32, UB_RD_LAT=1, accepted cycle 0 -> ub_rd_en cycles 1–4 with addr 0x10–0x13; stage_read cycles 2–5; first_out cycle 4; done cycle 39; busy cycles 1–39.
- Same command, weights_rdy_i raised at cycle 10 -> first read cycle 11, done cycle 49, cmd_ready low throughout.
- rows=3, pause_i high cycles 2–3 -> reads at cycles 1,4,5 with addr base..base+2; stage_read at 2,5,6; done cycle 40.
- base=0xFFFE, rows=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
- rows=0 -> done_o cycle 1, no ub_rd_en, cmd_ready high again cycle 2.
- abort_i at cycle 3 of rows=8 -> IDLE cycle 4, stage_read low from cycle 4, no done_o. A new command is then accepted normally. Separately, rst_ni low in DRAIN -> all outputs at reset values immediately.
